// File: rtl/oled_pkg.sv
// Shared constants for the OLED pixel path.
//   OLED_W / OLED_H  : panel geometry in pixels
//   PIX_W            : RGB565 colour width
//   TRANSPARENT_565  : colour key meaning "layer empty here"
//   WIN_NONE         : win_layer code reported when the background wins
package oled_pkg;

    localparam int unsigned OLED_W          = 96;
    localparam int unsigned OLED_H          = 64;
    localparam int unsigned PIX_W           = 16;
    localparam logic [15:0] TRANSPARENT_565 = 16'h0000;
    localparam logic [2:0]  WIN_NONE        = 3'd7;

endpackage

// File: rtl/layer_priority_mux.sv
// Combinational priority selector: picks the lowest-indexed eligible layer.
// Ports:
//   eligible   in  NUM_LAYERS        per-layer eligibility (enabled, visible, opaque)
//   colours    in  NUM_LAYERS*PIX_W  layer i at [i*PIX_W +: PIX_W]
//   colour     out PIX_W             winning colour, BG_COLOUR when none eligible
//   index      out 3                 winning layer index, WIN_NONE when none eligible
module layer_priority_mux
    import oled_pkg::*;
#(
    parameter int unsigned     NUM_LAYERS = 4,
    parameter int unsigned     PIX_W      = 16,
    parameter logic [PIX_W-1:0] BG_COLOUR = '0
) (
    input  logic [NUM_LAYERS-1:0]       eligible,
    input  logic [NUM_LAYERS*PIX_W-1:0] colours,
    output logic [PIX_W-1:0]            colour,
    output logic [2:0]                  index
);

    // Scan from lowest priority upward so the last hit is the highest-priority layer.
    always_comb begin
        colour = BG_COLOUR;
        index  = WIN_NONE;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                colour = colours[i*PIX_W +: PIX_W];
                index  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/oled_layer_compositor.sv
// N-layer pixel compositor feeding the OLED display driver.
// Frame-synchronous layer controls (enable/blink) are shadowed on each frame start,
// the highest-priority opaque visible layer wins, and the result is registered.
// Ports:
//   clk           in  1                 system clock
//   reset_n       in  1                 synchronous active-low reset
//   frame_begin   in  1                 frame start level from the display driver (async)
//   layer_colour  in  NUM_LAYERS*PIX_W  layer i at [i*PIX_W +: PIX_W]
//   layer_en      in  NUM_LAYERS        requested enable mask, takes effect next frame
//   layer_blink   in  NUM_LAYERS        requested blink mask, takes effect next frame
//   pixel_data    out PIX_W             composited colour
//   win_layer     out 3                 winning layer index, 7 = background
//   frame_count   out 16                frames since reset, wraps
module oled_layer_compositor #(
    parameter int unsigned      NUM_LAYERS   = 4,
    parameter int unsigned      PIX_W        = 16,
    parameter logic [PIX_W-1:0] TRANSPARENT  = PIX_W'(oled_pkg::TRANSPARENT_565),
    parameter logic [PIX_W-1:0] BG_COLOUR    = '0,
    parameter int unsigned      BLINK_FRAMES = 15
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_begin,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_colour,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS-1:0]       layer_blink,
    output logic [PIX_W-1:0]            pixel_data,
    output logic [2:0]                  win_layer,
    output logic [15:0]                 frame_count
);

    import oled_pkg::*;

    logic [1:0]            sync_q;
    logic                  edge_q;
    logic                  fb_pulse_q;
    logic [NUM_LAYERS-1:0] shadow_en_q;
    logic [NUM_LAYERS-1:0] shadow_blink_q;
    logic                  blink_phase_q;
    logic [7:0]            blink_cnt_q;
    logic [15:0]           frame_count_q;
    logic [PIX_W-1:0]      pixel_q;
    logic [2:0]            win_q;

    logic [NUM_LAYERS-1:0] eligible;
    logic [PIX_W-1:0]      mux_colour;
    logic [2:0]            mux_index;

    // A blinking layer is hidden during the odd blink phase.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eligible[i] = shadow_en_q[i]
                        && !(shadow_blink_q[i] && blink_phase_q)
                        && (layer_colour[i*PIX_W +: PIX_W] != TRANSPARENT);
        end
    end

    layer_priority_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .PIX_W      (PIX_W),
        .BG_COLOUR  (BG_COLOUR)
    ) u_mux (
        .eligible (eligible),
        .colours  (layer_colour),
        .colour   (mux_colour),
        .index    (mux_index)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q         <= '0;
            edge_q         <= 1'b0;
            fb_pulse_q     <= 1'b0;
            shadow_en_q    <= '0;
            shadow_blink_q <= '0;
            blink_phase_q  <= 1'b0;
            blink_cnt_q    <= '0;
            frame_count_q  <= '0;
            pixel_q        <= BG_COLOUR;
            win_q          <= WIN_NONE;
        end else begin
            // frame_begin is from a slower clock domain: two-flop synchroniser.
            sync_q     <= {sync_q[0], frame_begin};
            edge_q     <= sync_q[1];
            fb_pulse_q <= sync_q[1] & ~edge_q;

            if (fb_pulse_q) begin
                shadow_en_q    <= layer_en;
                shadow_blink_q <= layer_blink;
                frame_count_q  <= frame_count_q + 16'd1;
                if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 8'd1;
                end
            end

            pixel_q <= mux_colour;
            win_q   <= mux_index;
        end
    end

    assign pixel_data  = pixel_q;
    assign win_layer   = win_q;
    assign frame_count = frame_count_q;

endmodule
